nios_cpu_debug_slave_sysclk_mc: RTL

NIOS_CPU_DEBUG_SLAVE_SYSCLK_MC -- requirements
Module: nios_cpu_debug_slave_sysclk_mc

---
 rtl/nios_cpu_debug_slave_pkg.sv | 24 ++
 rtl/nios_cpu_debug_slave_sync.sv | 30 +++
 rtl/nios_cpu_debug_slave_sysclk_mc.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nios_cpu_debug_slave_pkg.sv
// Shared types and constants for the Nios debug-slave system-clock command path.
package nios_cpu_debug_slave_pkg;

    // Default parameter values for the top level.
    localparam int unsigned SrWDefault         = 38;
    localparam int unsigned IrWDefault         = 2;
    localparam int unsigned NumChDefault       = 4;
    localparam int unsigned SyncStagesDefault  = 2;

    // The action flag is the most significant bit of the shift-register snapshot.
    localparam int unsigned ActionBitOffset    = 1;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StIssue
    } state_e;

    // Index of the action flag within a snapshot of the given width.
    function automatic int unsigned action_bit_idx(input int unsigned sr_w);
        return sr_w - ActionBitOffset;
    endfunction

endpackage

// File: rtl/nios_cpu_debug_slave_sync.sv
// Single-bit multi-flop synchronizer for levels crossing in from the tck domain.
module nios_cpu_debug_slave_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the asynchronous level one stage per clock.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    // Synchronizer chain; cleared by reset so a pending edge is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/nios_cpu_debug_slave_sysclk_mc.sv
// Nios debug slave, system-clock side: synchronizes the virtual-JTAG update strobes,
// latches instruction and data, and issues one-hot valid/ready commands per channel.
// Optional command counter enabled by defining NIOS_CPU_DEBUG_SLAVE_CMD_CNT_EN.
module nios_cpu_debug_slave_sysclk_mc
    import nios_cpu_debug_slave_pkg::*;
#(
    parameter int unsigned SR_W        = SrWDefault,
    parameter int unsigned IR_W        = IrWDefault,
    parameter int unsigned NUM_CH      = NumChDefault,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [SR_W-1:0]   sr,
    input  logic [NUM_CH-1:0] cmd_ready,
    input  logic              overrun_clr,
    output logic [SR_W-1:0]   jdo,
    output logic [NUM_CH-1:0] take_action,
    output logic [NUM_CH-1:0] take_no_action,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       cmd_count
);

    localparam int unsigned ActIdx = action_bit_idx(SR_W);

    logic uir_sync;
    logic udr_sync;
    logic uir_prev_q, uir_prev_d;
    logic udr_prev_q, udr_prev_d;
    logic uir_rise;
    logic udr_rise;

    state_e            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [IR_W-1:0]   ch_q, ch_d;
    logic [SR_W-1:0]   jdo_q, jdo_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    logic [NUM_CH-1:0] ch_onehot;
    logic              ch_ok;
    logic              ready_sel;
    logic              handshake;

    nios_cpu_debug_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_uir (
        .clk   (clk),
        .reset (reset),
        .d_i   (vs_uir),
        .q_o   (uir_sync)
    );

    nios_cpu_debug_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_udr (
        .clk   (clk),
        .reset (reset),
        .d_i   (vs_udr),
        .q_o   (udr_sync)
    );

    assign uir_rise = uir_sync & ~uir_prev_q;
    assign udr_rise = udr_sync & ~udr_prev_q;

    // Decode the captured channel; out-of-range channels yield an all-zero vector.
    always_comb begin
        ch_onehot = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_onehot[i] = (ch_q == IR_W'(i));
        end
        ch_ok     = |ch_onehot;
        ready_sel = |(cmd_ready & ch_onehot);
        handshake = (state_q == StIssue) & valid_q & ready_sel;
    end

    // Next-state logic for the command FSM, instruction/data latches and overrun flag.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ch_d       = ch_q;
        jdo_d      = jdo_q;
        valid_d    = 1'b0;
        ovr_d      = ovr_q;
        uir_prev_d = uir_sync;
        udr_prev_d = udr_sync;

        if (uir_rise) begin
            ir_d = ir_in;
        end

        unique case (state_q)
            StIdle: begin
                if (udr_rise) begin
                    jdo_d   = sr;
                    // A simultaneous IR update must win over the stale register.
                    ch_d    = uir_rise ? ir_in : ir_q;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = ch_ok ? StIssue : StIdle;
            end
            StIssue: begin
                if (handshake) begin
                    state_d = StIdle;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Set has priority over clear.
        if (overrun_clr) begin
            ovr_d = 1'b0;
        end
        if (udr_rise && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ir_q       <= '0;
            ch_q       <= '0;
            jdo_q      <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            uir_prev_q <= 1'b0;
            udr_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ch_q       <= ch_d;
            jdo_q      <= jdo_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            uir_prev_q <= uir_prev_d;
            udr_prev_q <= udr_prev_d;
        end
    end

    assign jdo            = jdo_q;
    assign take_action    = (valid_q &&  jdo_q[ActIdx]) ? ch_onehot : '0;
    assign take_no_action = (valid_q && !jdo_q[ActIdx]) ? ch_onehot : '0;
    assign busy           = (state_q != StIdle);
    assign overrun        = ovr_q;

`ifdef NIOS_CPU_DEBUG_SLAVE_CMD_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of completed handshakes.
    always_comb begin
        cnt_d = cnt_q;
        if (handshake && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cmd_count = cnt_q;
`else
    assign cmd_count = 16'd0;
`endif

endmodule
